// File: rtl/mips_shift_pkg.sv
// Shared definitions for the iterative MIPS shift unit.
// Holds datapath defaults, shift op encodings and the FSM state type.
package mips_shift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift of a word by one position, selected by op.
// Ports: op (shift kind), work (current value), next (value after one step).
module shift_step
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] work,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = work;
        unique case (op)
            OP_SLL:  next = {work[WIDTH-2:0], 1'b0};
            OP_SRL:  next = {1'b0, work[WIDTH-1:1]};
            OP_SRA:  next = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_ROTR: next = {work[0], work[WIDTH-1:1]};
            default: next = work;
        endcase
    end

endmodule

// File: rtl/mips_seq_shifter.sv
// Iterative shifter: SLL/SRL/SRA/ROTR one bit per clock with start/busy/done.
// Ports: clk, rst (sync, active high), start, op, data_in, shamt_in -> busy, done, result.
module mips_seq_shifter
    import mips_shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] shamt_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   step_next;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] amount;

    // Only the low shift-amount bits matter (MIPS semantics).
    assign amount = shamt_in[SHAMT_W-1:0];

    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shamt_in[WIDTH-1:SHAMT_W];

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op   (op_q),
        .work (work),
        .next (step_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            op_q   <= OP_SLL;
            count  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work  <= data_in;
                        op_q  <= op;
                        count <= amount;
                        busy  <= 1'b1;
                        if (amount == CNT_ZERO) begin
                            // Zero shift goes straight to completion.
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= data_in;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work  <= step_next;
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        // Last step: publish the value being shifted in now.
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= step_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_seq_shifter.sv
// Self-checking bench for mips_seq_shifter.
// Vector table plus scoreboard of expected result and completion cycle.
module tb_mips_seq_shifter;
    import mips_shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0;
    logic [31:0] shamt_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] shamt;
        logic [31:0] res;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    mips_seq_shifter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt_in (shamt_in),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d,
                                          input logic [31:0] s);
        int n;
        n = int'(s[4:0]);
        case (o)
            OP_SLL:  return d << n;
            OP_SRL:  return d >> n;
            OP_SRA:  return $signed(d) >>> n;
            default: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
    endfunction

    // Scoreboard consumer: every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("done_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    // Called just after a negedge; returns just after a negedge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] d,
                         input logic [31:0] s, input logic [31:0] r);
        exp_t e;
        int   k;
        op = o;
        data_in = d;
        shamt_in = s;
        start = 1'b1;
        e.res = r;
        e.at = cyc + 1 + int'(s[4:0]);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // Disturb inputs: they must not affect an operation in flight.
        op = ~o;
        data_in = ~d;
        shamt_in = s + 32'd3;
        k = 0;
        while (!done && k < 40) begin
            chk("busy_in_shift", {31'b0, busy}, 32'd1);
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL timeout: got no done required done within 40 cycles");
            sb.delete();
        end else begin
            chk("busy_in_done", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("busy_after", {31'b0, busy}, 32'd0);
        chk("result_hold", result, r);
    endtask

    initial begin
        int k;
        logic [1:0]  ro;
        logic [31:0] rd;
        logic [31:0] rs;

        vecs[0] = '{OP_SLL,  32'h0000_0001, 32'h0000_0004, 32'h0000_0010};
        vecs[1] = '{OP_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF};
        vecs[2] = '{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
        vecs[3] = '{OP_ROTR, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        vecs[4] = '{OP_SLL,  32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF};
        vecs[5] = '{OP_ROTR, 32'h1234_5678, 32'h0000_0008, 32'h7812_3456};
        vecs[6] = '{OP_SRA,  32'h7FFF_0000, 32'h0000_0010, 32'h0000_7FFF};
        vecs[7] = '{OP_SLL,  32'h0000_FFFF, 32'h0000_0023, 32'h0007_FFF8};
        vecs[8] = '{OP_SRA,  32'hF000_0000, 32'h0000_0004, 32'hFF00_0000};
        vecs[9] = '{OP_SRL,  32'hF000_0000, 32'h0000_0020, 32'hF000_0000};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].res);
            @(negedge clk);
        end

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            rd = $urandom;
            rs = $urandom;
            do_op(ro, rd, rs, model(ro, rd, rs));
        end

        // Start requests during SHIFT and DONE must be ignored.
        op = OP_SLL;
        data_in = 32'h0000_0003;
        shamt_in = 32'h0000_0005;
        start = 1'b1;
        sb.push_back('{32'h0000_0060, cyc + 6});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = OP_SRL;
        data_in = 32'hFFFF_FFFF;
        shamt_in = 32'h0000_0001;
        start = 1'b1;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL busy_seq_timeout: got no done required done");
            sb.delete();
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_seq_idle", {31'b0, busy}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("busy_seq_hold", result, 32'h0000_0060);
            chk("busy_seq_nobusy", {31'b0, busy}, 32'd0);
        end

        // Reset in the middle of a 10-step shift aborts it.
        op = OP_SLL;
        data_in = 32'h0000_0001;
        shamt_in = 32'h0000_000A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_quiet", result, 32'd0);
        do_op(OP_SRL, 32'h0000_0100, 32'h0000_0004, 32'h0000_0010);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
